// File: rtl/hazard_pkg.sv
// Shared constants for the hazard detection unit: hazType codes, memory-wait
// FSM encodings and the load-use compare used by the top level.
package hazard_pkg;

  typedef enum logic [1:0] {
    HAZ_NONE    = 2'b00,
    HAZ_LOADUSE = 2'b01,
    HAZ_FLUSH   = 2'b10,
    HAZ_FREEZE  = 2'b11
  } haz_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } mem_state_e;

  // $zero is hardwired, so a load targeting it never creates a dependency.
  function automatic logic load_use(input logic       ex_mem_read,
                                    input logic [4:0] ex_rt,
                                    input logic [4:0] id_rs,
                                    input logic [4:0] id_rt,
                                    input logic       id_uses_rt);
    return ex_mem_read && (ex_rt != 5'd0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/hazard_mem_wait_fsm.sv
// Tracks a multi-cycle data-memory access in MEM and asks for a freeze of
// exactly MEM_LAT-1 cycles per access.
//   state | meaning
//   IDLE  | no access in flight; a new access starts the freeze
//   WAIT  | access in flight, pipeline frozen, cnt counts frozen cycles
//   DONE  | access completes; same access still visible, not restarted
module hazard_mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_LAT = 3
) (
  input  logic Clk,
  input  logic Rst,
  input  logic EX_MEM_memAccess,
  output logic freeze,
  output logic inDone
);

  localparam int CW = $clog2(MEM_LAT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((MEM_LAT >= 2) ? (MEM_LAT - 2) : 0);
  localparam bit MEM_MULTI = (MEM_LAT > 1);

  mem_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mem_start;

  assign mem_start = (state_q == IDLE) && EX_MEM_memAccess && MEM_MULTI;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_start) begin
          cnt_d   = CW'(1);
          state_d = (MEM_LAT == 2) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) state_d = DONE;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    freeze = mem_start || (state_q == WAIT);
    inDone = (state_q == DONE);
  end

endmodule

// File: rtl/hazard_detect_unit.sv
// Hazard detection: priority-encodes memory freeze, load-use stall and
// control-flow flush into hazType, and counts hazard cycles (saturating).
module hazard_detect_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_LAT = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       IF_ID_rs,
  input  logic [4:0]       IF_ID_rt,
  input  logic             ID_uses_rt,
  input  logic             ID_EX_memRead,
  input  logic [4:0]       ID_EX_rt,
  input  logic             branchTaken,
  input  logic             jump,
  input  logic             EX_MEM_memAccess,
  output logic [1:0]       hazType,
  output logic [CNT_W-1:0] hazCycles
);

  logic             freeze, in_done;
  logic             load_use_hit, ctrl_flow;
  haz_t             haz;
  logic [CNT_W-1:0] hazcyc_q, hazcyc_d;

  hazard_mem_wait_fsm #(.MEM_LAT(MEM_LAT)) u_mem_wait (
    .Clk              (Clk),
    .Rst              (Rst),
    .EX_MEM_memAccess (EX_MEM_memAccess),
    .freeze           (freeze),
    .inDone           (in_done)
  );

  assign load_use_hit = load_use(ID_EX_memRead, ID_EX_rt, IF_ID_rs, IF_ID_rt, ID_uses_rt);
  assign ctrl_flow    = branchTaken || jump;

  // DONE never freezes: the access still visible in MEM is the one finishing.
  always_comb begin
    haz = HAZ_NONE;
    if (Rst)                     haz = HAZ_NONE;
    else if (freeze && !in_done) haz = HAZ_FREEZE;
    else if (load_use_hit)       haz = HAZ_LOADUSE;
    else if (ctrl_flow)          haz = HAZ_FLUSH;
  end

  assign hazType = haz;

  always_comb begin
    hazcyc_d = hazcyc_q;
    if ((haz != HAZ_NONE) && (hazcyc_q != '1)) hazcyc_d = hazcyc_q + CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Rst) hazcyc_q <= '0;
    else     hazcyc_q <= hazcyc_d;
  end

  assign hazCycles = hazcyc_q;

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Scoreboard bench: four hazard_detect_unit instances (MEM_LAT 3/4/3/1, one
// with a 4-bit counter) share one directed stimulus stream.
module tb_hazard_detect_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs, idrt, exrt;
  logic        uses_rt, memread, br, jmp, mem;

  logic [1:0]  h3, h4, hs, h1;
  logic [15:0] c3, c4, c1;
  logic [3:0]  cs;

  typedef struct {
    string name;
    int    h3, h4, h1;
    int    c3, c4, cs, c1;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  hazard_detect_unit #(.MEM_LAT(3), .CNT_W(16)) dut3 (
    .Clk(clk), .Rst(rst), .IF_ID_rs(rs), .IF_ID_rt(idrt), .ID_uses_rt(uses_rt),
    .ID_EX_memRead(memread), .ID_EX_rt(exrt), .branchTaken(br), .jump(jmp),
    .EX_MEM_memAccess(mem), .hazType(h3), .hazCycles(c3));

  hazard_detect_unit #(.MEM_LAT(4), .CNT_W(16)) dut4 (
    .Clk(clk), .Rst(rst), .IF_ID_rs(rs), .IF_ID_rt(idrt), .ID_uses_rt(uses_rt),
    .ID_EX_memRead(memread), .ID_EX_rt(exrt), .branchTaken(br), .jump(jmp),
    .EX_MEM_memAccess(mem), .hazType(h4), .hazCycles(c4));

  hazard_detect_unit #(.MEM_LAT(3), .CNT_W(4)) duts (
    .Clk(clk), .Rst(rst), .IF_ID_rs(rs), .IF_ID_rt(idrt), .ID_uses_rt(uses_rt),
    .ID_EX_memRead(memread), .ID_EX_rt(exrt), .branchTaken(br), .jump(jmp),
    .EX_MEM_memAccess(mem), .hazType(hs), .hazCycles(cs));

  hazard_detect_unit #(.MEM_LAT(1), .CNT_W(16)) dut1 (
    .Clk(clk), .Rst(rst), .IF_ID_rs(rs), .IF_ID_rt(idrt), .ID_uses_rt(uses_rt),
    .ID_EX_memRead(memread), .ID_EX_rt(exrt), .branchTaken(br), .jump(jmp),
    .EX_MEM_memAccess(mem), .hazType(h1), .hazCycles(c1));

  task automatic cmp(input string nm, input logic [31:0] act, input int expv);
    if (expv < 0) return;
    total++;
    if (act === 32'(expv)) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
  endtask

  // Monitor: hazType is Mealy, so sample it mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp({e.name, ".haz_L3"},  32'(h3), e.h3);
      cmp({e.name, ".haz_L4"},  32'(h4), e.h4);
      cmp({e.name, ".haz_L3w4"}, 32'(hs), e.h3);
      cmp({e.name, ".haz_L1"},  32'(h1), e.h1);
      cmp({e.name, ".cyc_L3"},  32'(c3), e.c3);
      cmp({e.name, ".cyc_L4"},  32'(c4), e.c4);
      cmp({e.name, ".cyc_L3w4"}, 32'(cs), e.cs);
      cmp({e.name, ".cyc_L1"},  32'(c1), e.c1);
    end
  end

  task automatic setin(input logic r, input logic [4:0] a, input logic [4:0] b,
                       input logic u, input logic m, input logic [4:0] e,
                       input logic bt, input logic j, input logic ma);
    rst = r; rs = a; idrt = b; uses_rt = u; memread = m; exrt = e;
    br = bt; jmp = j; mem = ma;
  endtask

  task automatic zeros();
    setin(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Push the expectation for the current cycle, then advance one clock.
  task automatic step(input string nm, input int e3, input int e4, input int e1,
                      input int k3, input int k4, input int ks, input int k1);
    exp_t e;
    e.name = nm; e.h3 = e3; e.h4 = e4; e.h1 = e1;
    e.c3 = k3; e.c4 = k4; e.cs = ks; e.c1 = k1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    setin(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;

    // reset with memAccess and branch asserted
    setin(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    step("rst0", 0, 0, 0, 0, 0, 0, 0);
    step("rst1", 0, 0, 0, 0, 0, 0, 0);
    zeros();
    step("idle", 0, 0, 0, 0, 0, 0, 0);

    // load-use
    setin(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    step("lu_rs", 1, 1, 1, 0, 0, 0, 0);
    zeros();
    step("lu_clr", 0, 0, 0, 1, 1, 1, 1);
    setin(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    step("lu_zero", 0, 0, 0, 1, 1, 1, 1);
    setin(1'b0, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    step("lu_rt_unused", 0, 0, 0, 1, 1, 1, 1);
    setin(1'b0, 5'd0, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    step("lu_rt_used", 1, 1, 1, 1, 1, 1, 1);
    zeros();
    step("lu_end", 0, 0, 0, 2, 2, 2, 2);

    // single memory access held 3 cycles
    setin(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    step("mw_a", 3, 3, 0, 2, 2, 2, 2);
    step("mw_b", 3, 3, 0, 3, 3, 3, 2);
    step("mw_c", 0, 3, 0, 4, 4, 4, 2);
    zeros();
    step("mw_d", 0, 0, 0, 4, 5, 4, 2);
    step("mw_e", 0, 0, 0, 4, 5, 4, 2);

    // back-to-back accesses
    setin(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    step("bb_f", 3, 3, 0, 4, 5, 4, 2);
    step("bb_g", 3, 3, 0, 5, 6, 5, 2);
    step("bb_h", 0, 3, 0, 6, 7, 6, 2);
    step("bb_i", 3, 0, 0, 6, 8, 6, 2);
    step("bb_j", 3, 3, 0, 7, 8, 7, 2);
    step("bb_k", 0, 3, 0, 8, 9, 8, 2);
    zeros();
    step("bb_l", 0, 3, 0, 8, 10, 8, 2);
    step("bb_m", 0, 0, 0, 8, 11, 8, 2);

    // priority: memAccess + load-use + branch
    setin(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
    step("pr_n", 3, 3, 1, 8, 11, 8, 2);
    step("pr_o", 3, 3, 1, 9, 12, 9, 3);
    step("pr_p", 1, 3, 1, 10, 13, 10, 4);
    setin(1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    step("pr_q", 2, 2, 2, 11, 14, 11, 5);
    zeros();
    step("pr_r", 0, 0, 0, 12, 15, 12, 6);

    // continuous jumps: 4-bit counter saturates at 15
    setin(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step("sat_s", 2, 2, 2, 12, 15, 12, 6);
    step("sat_t", 2, 2, 2, 13, 16, 13, 7);
    step("sat_u", 2, 2, 2, 14, 17, 14, 8);
    step("sat_v", 2, 2, 2, 15, 18, 15, 9);
    step("sat_w", 2, 2, 2, 16, 19, 15, 10);
    step("sat_x", 2, 2, 2, 17, 20, 15, 11);
    zeros();
    step("sat_y", 0, 0, 0, 18, 21, 15, 12);

    // reset in the middle of a wait
    setin(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    step("mr_start", 3, 3, 0, 18, 21, 15, 12);
    setin(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("mr_rst", 0, 0, 0, 19, 22, 15, 12);
    zeros();
    step("mr_idle", 0, 0, 0, 0, 0, 0, 0);
    setin(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    step("mr_again", 3, 3, 0, 0, 0, 0, 0);
    zeros();
    step("mr_wait", 3, 3, 0, 1, 1, 1, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not end, expected end before 100000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_detect_unit.md
Name: hazard_detect_unit

Overview:
Produces the 2-bit hazType code that the pipeline register controller latches on the falling edge of Clk.
It detects load-use data hazards and taken branches/jumps in ID, and tracks multi-cycle data-memory accesses in MEM with an internal FSM and counter.
It sits between the ID/EX/MEM pipeline registers and the pipeline register controller, and also keeps a saturating hazard-cycle performance counter.

Parameters:
MEM_LAT, 3, data-memory access latency in cycles (legal 1..16); a MEM access freezes the pipeline for MEM_LAT-1 cycles
CNT_W, 16, width of the hazard-cycle performance counter

Ports:
Clk  input  1  clock; all state updates on the rising edge
Rst  input  1  synchronous, active-high reset
IF_ID_rs  input  5  rs field of the instruction in ID
IF_ID_rt  input  5  rt field of the instruction in ID
ID_uses_rt  input  1  instruction in ID reads rt as a source
ID_EX_memRead  input  1  instruction in EX is a load
ID_EX_rt  input  5  destination register of the load in EX
branchTaken  input  1  branch in ID resolved taken
jump  input  1  jump in ID
EX_MEM_memAccess  input  1  instruction in MEM performs a data-memory read or write
hazType  output  2  00 none, 01 load-use stall + bubble, 10 flush IF/ID, 11 freeze all stages
hazCycles  output  CNT_W  count of cycles with hazType != 00, saturating

Behaviour:
- Reset: while Rst=1, hazType=00 (forced combinationally). On the Rst rising edge: state<=IDLE, cnt<=0, hazCycles<=0.
- Reset mid-stall abandons the stall. The next cycle is IDLE.
- hazType is Mealy: a function of the registered state and the current inputs. It must be stable before the falling edge of Clk.
- loadUse = ID_EX_memRead & (ID_EX_rt!=0) & ((ID_EX_rt==IF_ID_rs) | (ID_uses_rt & ID_EX_rt==IF_ID_rt)).
- ctrlFlow = branchTaken | jump.
- memStart = (state==IDLE) & EX_MEM_memAccess & (MEM_LAT>1).
- Priority: memStart or state==WAIT -> 11; else loadUse -> 01; else ctrlFlow -> 10; else 00.
- FSM, with cnt of width clog2(MEM_LAT)+1:
  - IDLE: if memStart, cnt<=1 and next = (MEM_LAT==2) ? DONE : WAIT; else stay in IDLE.
  - WAIT: hazType=11. If cnt==MEM_LAT-2, go to DONE; else cnt<=cnt+1.
  - DONE: EX_MEM_memAccess is ignored because the same access is still visible. Lower-priority hazards are evaluated normally. Next state is IDLE unconditionally.
- Result: each access gives exactly MEM_LAT-1 consecutive 11 cycles.
- Back-to-back accesses: memAccess in the first IDLE after DONE starts a new wait.
- MEM_LAT==1: the FSM never leaves IDLE and 11 is never produced.
- Load-use with a branch in ID gives 01 first. The branch is re-evaluated after the bubble and gives 10.
- A branch or load-use present during a memory wait is suppressed. It is held by the frozen stages and emitted after DONE.
- hazCycles increments by 1 on each rising edge where Rst=0 and hazType!=00, and holds at 2^CNT_W-1.
- Register $zero is never a load-use hazard.

Decomposition:
- Shared package hazard_pkg:
  - HAZ_NONE=2'b00, HAZ_LOADUSE=2'b01, HAZ_FLUSH=2'b10, HAZ_FREEZE=2'b11.
  - FSM encodings IDLE=2'b00, WAIT=2'b01, DONE=2'b10.
  - The controller is updated to use the same constants.
- Sub-module hazard_mem_wait_fsm:
  - Holds the state and cnt.
  - Inputs Clk, Rst, EX_MEM_memAccess. Outputs freeze and inDone.
  - The top level does the priority encoding, load-use compare and perf counter.

Test Plan:
1. Reset/idle: Rst=1 for 2 cycles with memAccess=1 and branchTaken=1 -> hazType=00, hazCycles=0; after release, with all inputs 0 -> hazType=00.
2. Load-use: ID_EX_memRead=1, ID_EX_rt=5, IF_ID_rs=5 -> hazType=01 for 1 cycle. Repeat with rt=0 -> 00. Repeat with IF_ID_rt=5 and ID_uses_rt=0 -> 00.
3. Memory wait with MEM_LAT=3: memAccess held 3 cycles -> hazType 11,11,00, then IDLE. With MEM_LAT=4 -> 11,11,11,00. hazCycles is 2 and 3 respectively.
4. Back-to-back accesses with MEM_LAT=3: memAccess=1 for 6 cycles -> 11,11,00,11,11,00.
5. Priority: memAccess, loadUse and branchTaken all asserted with MEM_LAT=3 -> 11,11, then DONE cycle 01; next cycle with loadUse cleared and branch still set -> 10.
6. Saturation and mid-stall reset: CNT_W=4 with continuous hazards -> hazCycles stops at 15. Rst asserted in WAIT -> hazType=00 immediately and state=IDLE the next cycle.
